// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide over a
// shared 2*WIDTH accumulator, with sign handling by magnitude conversion and post-fix.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_div_done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_is_mul;
  logic                 r_signed;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;

  logic                 w_accept;
  logic                 w_div0;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_msum;
  logic [WIDTH:0]       w_rsh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rdiff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  function automatic logic [WIDTH-1:0] f_neg(input logic signed [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic signed [2*WIDTH-1:0] x);
    return -x;
  endfunction

  assign w_accept = (r_state == S_IDLE) && (mult_start || div_start);
  assign w_div0   = !r_is_mul && (r_b == '0);
  assign w_sa     = r_signed & r_a[WIDTH-1];
  assign w_sb     = r_signed & r_b[WIDTH-1];
  assign w_mag_a  = w_sa ? f_neg(r_a) : r_a;
  assign w_mag_b  = w_sb ? f_neg(r_b) : r_b;

  // Multiply step keeps the carry out of the upper-half add for the right shift.
  assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  // Divide step compares the shifted partial remainder including the bit shifted out.
  assign w_rsh    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge     = w_rsh >= {1'b0, r_b};
  assign w_rdiff  = w_rsh[WIDTH-1:0] - r_b;

  assign w_prod   = (r_sign_a ^ r_sign_b) ? f_neg2(r_acc) : r_acc;
  assign w_quo    = (r_sign_a ^ r_sign_b) ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem    = r_sign_a ? f_neg(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_PREP;
      S_PREP:  w_next = w_div0 ? S_DONE : S_ITER;
      S_ITER:  if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mult_div_done = (r_state == S_DONE);
    busy          = (r_state != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_is_mul    <= 1'b0;
      r_signed    <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_mul    <= mult_start;
            r_signed    <= is_signed;
            r_a         <= op_a;
            r_b         <= op_b;
            div_by_zero <= 1'b0;
          end
        end
        S_PREP: begin
          r_sign_a <= w_sa;
          r_sign_b <= w_sb;
          r_a      <= w_mag_a;
          r_b      <= w_mag_b;
          r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
          r_cnt    <= CW'(WIDTH);
          if (w_div0) begin
            hi_out      <= r_a;
            lo_out      <= '1;
            div_by_zero <= 1'b1;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_mul) r_acc <= {w_msum, r_acc[WIDTH-1:1]};
          else          r_acc <= {(w_ge ? w_rdiff : w_rsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        end
        S_FIX: begin
          if (r_is_mul) begin
            hi_out <= w_prod[2*WIDTH-1:WIDTH];
            lo_out <= w_prod[WIDTH-1:0];
          end else begin
            hi_out <= w_rem;
            lo_out <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: latency, busy window, signed/unsigned
// results, divide by zero, ignored starts and mid-operation reset.
module tb_mult_div_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mult_div_done;
  logic        busy;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;
  int lat;
  int bcnt;
  int dcnt;

  always #5 CLK = ~CLK;

  mult_div_sequencer #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .mult_start(mult_start), .div_start(div_start),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .hi_out(hi_out),
    .lo_out(lo_out), .mult_div_done(mult_div_done), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start on one cycle, then count cycles until done (n=1 is the cycle after start).
  task automatic run(input logic m, input logic d, input logic s,
                     input logic [31:0] a, input logic [31:0] b, input int inj);
    @(negedge CLK);
    mult_start = m; div_start = d; is_signed = s; op_a = a; op_b = b;
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        mult_start = 1'b0; div_start = 1'b0; is_signed = ~s;
        op_a = 32'hDEAD_BEEF; op_b = 32'h5;
      end
      if (n == inj) begin mult_start = 1'b1; op_a = 32'h7; op_b = 32'h7; end
      if (n == inj + 1) mult_start = 1'b0;
      if (busy) bcnt++;
      if (mult_div_done) begin lat = n; break; end
    end
  endtask

  task automatic after_done(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    @(negedge CLK);
    check({tag, "_done_width"}, 64'(mult_div_done), 64'(0));
    check({tag, "_busy_off"}, 64'(busy), 64'(0));
    check({tag, "_hold"}, {hi_out, lo_out}, {hi, lo});
  endtask

  initial begin
    #1;
    check("reset_outputs", {hi_out, lo_out}, 64'h0);
    check("reset_flags", {61'h0, mult_div_done, busy, div_by_zero}, 64'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    run(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -5);
    check("umul_lat", 64'(lat), 64'(35));
    check("umul_busy", 64'(bcnt), 64'(35));
    check("umul_res", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    after_done("umul", 32'hFFFF_FFFE, 32'h0000_0001);

    run(1, 0, 1, 32'hFFFF_FFFD, 32'd7, -5);
    check("smul_lat", 64'(lat), 64'(35));
    check("smul_res", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    after_done("smul", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    run(0, 1, 1, 32'hFFFF_FFF9, 32'd2, -5);
    check("sdiv_lat", 64'(lat), 64'(35));
    check("sdiv_res", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    run(0, 1, 1, 32'd7, 32'hFFFF_FFFE, -5);
    check("sdiv_negb", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFD);

    run(0, 1, 0, 32'd100, 32'd7, -5);
    check("udiv_res", {hi_out, lo_out}, {32'd2, 32'd14});
    check("udiv_dbz", 64'(div_by_zero), 64'(0));

    run(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, -5);
    check("sdiv_ovf", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

    run(0, 1, 0, 32'h0000_1234, 32'h0, -5);
    check("dbz_lat", 64'(lat), 64'(2));
    check("dbz_busy", 64'(bcnt), 64'(2));
    check("dbz_flag", 64'(div_by_zero), 64'(1));
    check("dbz_res", {hi_out, lo_out}, 64'h0000_1234_FFFF_FFFF);
    after_done("dbz", 32'h0000_1234, 32'hFFFF_FFFF);
    check("dbz_held", 64'(div_by_zero), 64'(1));

    run(1, 0, 0, 32'd3, 32'd4, -5);
    check("mul34_dbz_clr", 64'(div_by_zero), 64'(0));
    check("mul34_res", {hi_out, lo_out}, 64'd12);

    run(1, 1, 0, 32'd6, 32'd3, 10);
    check("both_lat", 64'(lat), 64'(35));
    check("both_res", {hi_out, lo_out}, 64'd18);
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (mult_div_done) dcnt++;
    end
    check("ignored_start_done", 64'(dcnt), 64'(0));
    check("ignored_start_res", {hi_out, lo_out}, 64'd18);

    @(negedge CLK);
    mult_start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
    @(negedge CLK);
    mult_start = 1'b0;
    repeat (19) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_mid_out", {hi_out, lo_out}, 64'h0);
    check("rst_mid_flags", {61'h0, mult_div_done, busy, div_by_zero}, 64'h0);
    dcnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      if (mult_div_done || busy) dcnt++;
    end
    RST = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (mult_div_done || busy) dcnt++;
    end
    check("rst_no_done", 64'(dcnt), 64'(0));

    run(1, 0, 0, 32'd5, 32'd5, -5);
    check("mul55_lat", 64'(lat), 64'(35));
    check("mul55_res", {hi_out, lo_out}, 64'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative multiply/divide unit and its sequencing FSM, started by the main sequence controller via mult_start/div_start.
- Returns mult_div_done, on which the controller leaves its wait state and loads HI/LO.
- One shared 2*WIDTH shift register per operation: shift-add for multiply, restoring for divide.
- Sign handling by magnitude conversion before iteration and correction after it.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous active-low reset.
mult_start  input  1  one-cycle start of multiply (A*B).
div_start  input  1  one-cycle start of divide (A/B).
is_signed  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu); sampled with start.
op_a  input  WIDTH  multiplicand / dividend; sampled with start.
op_b  input  WIDTH  multiplier / divisor; sampled with start.
hi_out  output  WIDTH  product upper half / remainder.
lo_out  output  WIDTH  product lower half / quotient.
mult_div_done  output  1  one-cycle pulse; hi_out/lo_out valid.
busy  output  1  high from the cycle after an accepted start through the DONE cycle.
div_by_zero  output  1  high with mult_div_done when a divide had op_b==0; held until the next accepted start.

Behaviour:
- Clock and reset: single clock CLK; RST asynchronous active-low.
- Reset state: IDLE. hi_out, lo_out, mult_div_done, busy and div_by_zero all 0. Internal registers cleared.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - A start is accepted only in IDLE.
  - If mult_start and div_start are both high, multiply wins; the div request is dropped.
  - Accepted start latches op type, is_signed, op_a and op_b, then goes to PREP.
  - Starts outside IDLE, including in DONE, are ignored.
- PREP (1 cycle):
  - Signed: latch sign_a and sign_b; replace each operand with its magnitude (two's complement negate if negative).
  - Unsigned: both signs are 0.
  - Load accumulator {WIDTH'b0, |a|} and iteration counter = WIDTH.
  - Divide with op_b==0: go straight to DONE, with hi_out=op_a (original), lo_out=all ones, div_by_zero=1.
  - Otherwise go to ITER.
- ITER (exactly WIDTH cycles, counter decrements each cycle):
  - Multiply: if acc[0], add |b| to acc upper half with carry kept in a WIDTH+1 bit sum; then shift {carry,acc} right 1.
  - Divide: shift acc left 1; trial = acc upper half minus |b|; if trial is non-negative, the upper half becomes trial and acc[0]=1.
  - When counter reaches 1, go to FIX.
- FIX (1 cycle):
  - Multiply: if sign_a^sign_b, negate the full 2*WIDTH product. hi_out=upper half, lo_out=lower half.
  - Divide: quotient negated if sign_a^sign_b; remainder negated if sign_a (remainder takes the dividend's sign). lo_out=quotient, hi_out=remainder.
  - Signed overflow case -2^(WIDTH-1) / -1: lo_out=0x80000000, hi_out=0 (natural truncation, no exception).
- DONE (1 cycle): mult_div_done=1, busy=1, then go to IDLE.
- Latency, with start high in cycle k:
  - PREP in k+1, ITER in k+2..k+WIDTH+1, FIX in k+WIDTH+2.
  - mult_div_done in k+WIDTH+3, i.e. k+35 for WIDTH=32.
  - Divide by zero: mult_div_done in k+2.
- Output hold:
  - hi_out and lo_out change only in FIX, or in PREP for divide by zero.
  - They stay stable after DONE until the next accepted start reaches FIX, so the controller may load HI/LO in the cycle after done.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse is generated.
- div_by_zero is cleared on the next accepted start.

Test Plan:
- Unsigned mult, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done at start+35; hi_out=0xFFFFFFFE, lo_out=0x00000001; busy high for 35 cycles.
- Signed mult, op_a=0xFFFFFFFD (-3), op_b=7 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB (-21); done exactly one cycle wide.
- Signed div, op_a=-7 (0xFFFFFFF9), op_b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Unsigned div 100/7 -> lo_out=14, hi_out=2.
- Div by zero, op_a=0x1234, op_b=0 -> done at start+2, div_by_zero=1, hi_out=0x1234, lo_out=0xFFFFFFFF. A following mult 3*4 clears div_by_zero and gives lo_out=12.
- mult_start and div_start high together with op_a=6, op_b=3 -> multiply performed, lo_out=18. A second mult_start pulsed at start+10 is ignored: no extra done, results unchanged.
- RST low at start+20 of a mult -> outputs 0, state IDLE, no done pulse. After release, a new mult 5*5 completes with lo_out=25 at start+35.
